// File: rtl/uart_rx_pkg.sv
// Shared types and default parameters for the UART receive path.
// Imported by the receiver top; the FIFO is type-agnostic.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int FIFO_DEPTH_DEF   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB for full/empty.
// Head entry is read combinationally; zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;

  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, baud-timed sampling FSM and
// a receive FIFO with valid/ready drain and error pulses.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        uart_rx,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e   state_q;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        frame_err_q;
  logic        overrun_q;

  logic rx_s;
  logic push;
  logic pop;
  logic empty;
  logic full;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rx};
  end

  // Push lands on the stop-sample cycle so the byte shows next cycle.
  assign push = (state_q == STOP) && (cnt_q == FULL_C) && rx_s;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_q      <= rx_s;
      frame_err_q <= 1'b0;
      overrun_q   <= push && full && !pop;
      unique case (state_q)
        IDLE: begin
          if (prev_q && !rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_C) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_C) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_C) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            frame_err_q <= !rx_s;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (data_o),
    .empty_o (empty),
    .full_o  (full),
    .level_o (level_o)
  );

  assign valid_o     = !empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit, depth 4.
// Serial frames are bit-banged; pulse counters watch the outputs.
module tb_uart_rx_fifo;

  logic       clk_in;
  logic       reset;
  logic       uart_rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] level_o;
  logic       frame_err_o;
  logic       overrun_o;

  int passed;
  int total;
  int fe_n;
  int ov_n;
  int vld_n;
  int both_n;
  logic [7:0] last_data;

  uart_rx_fifo #(
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_err_o) fe_n++;
    if (overrun_o) ov_n++;
    if (valid_o) begin
      vld_n++;
      last_data = data_o;
    end
    if (frame_err_o && overrun_o) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Frame = start, 8 data LSB first, stop; optional pop on the push cycle.
  task automatic send(input logic [7:0] b, input logic stop,
                      input logic pop_at_stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = f[k];
      for (int j = 0; j < 16; j++) begin
        if (pop_at_stop && k == 9 && j == 10) ready_i = 1'b1;
        if (pop_at_stop && k == 9 && j == 11) ready_i = 1'b0;
        cycles(1);
      end
    end
    uart_rx = 1'b1;
    cycles(16);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk_in);
    chk(tag, 32'(data_o), 32'(exp));
    ready_i = 1'b1;
    @(posedge clk_in);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    int fe0, ov0, vl0;
    logic [7:0] part;
    passed  = 0;
    total   = 0;
    fe_n    = 0;
    ov_n    = 0;
    vld_n   = 0;
    both_n  = 0;
    last_data = 8'h00;
    reset   = 1'b1;
    uart_rx = 1'b1;
    ready_i = 1'b0;

    cycles(3);
    @(negedge clk_in);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_ferr", 32'(frame_err_o), 0);
    chk("rst_ovr", 32'(overrun_o), 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    cycles(10);

    // A5 drained immediately
    ready_i = 1'b1;
    fe0 = fe_n;
    vl0 = vld_n;
    send(8'hA5, 1'b1, 1'b0);
    cycles(4);
    chk("a5_vcycles", 32'(vld_n - vl0), 1);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_ferr", 32'(fe_n - fe0), 0);
    chk("a5_level", 32'(level_o), 0);
    ready_i = 1'b0;

    // short low glitch
    vl0 = vld_n;
    uart_rx = 1'b0;
    cycles(5);
    uart_rx = 1'b1;
    cycles(40);
    chk("gl_valid", 32'(vld_n - vl0), 0);
    chk("gl_ferr", 32'(fe_n - fe0), 0);
    chk("gl_level", 32'(level_o), 0);

    // bad stop bit
    vl0 = vld_n;
    send(8'h3C, 1'b0, 1'b0);
    cycles(4);
    chk("fe_pulse", 32'(fe_n - fe0), 1);
    chk("fe_level", 32'(level_o), 0);
    chk("fe_valid", 32'(vld_n - vl0), 0);

    // fill and overrun
    ov0 = ov_n;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    chk("ov_level4", 32'(level_o), 4);
    chk("ov_none4", 32'(ov_n - ov0), 0);
    send(8'h05, 1'b1, 1'b0);
    chk("ov_level5", 32'(level_o), 4);
    chk("ov_pulse", 32'(ov_n - ov0), 1);
    pop_chk("ov_pop1", 8'h01);
    pop_chk("ov_pop2", 8'h02);
    pop_chk("ov_pop3", 8'h03);
    pop_chk("ov_pop4", 8'h04);
    cycles(2);
    chk("ov_empty", 32'(level_o), 0);

    // push and pop together while full
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    ov0 = ov_n;
    send(8'h77, 1'b1, 1'b1);
    chk("fp_level", 32'(level_o), 4);
    chk("fp_ovr", 32'(ov_n - ov0), 0);
    pop_chk("fp_pop1", 8'h22);
    pop_chk("fp_pop2", 8'h33);
    pop_chk("fp_pop3", 8'h44);
    pop_chk("fp_pop4", 8'h77);

    // reset in the middle of data bit 4
    cycles(4);
    send(8'h99, 1'b1, 1'b0);
    chk("mr_pre_lvl", 32'(level_o), 1);
    part = 8'h5A;
    uart_rx = 1'b0;
    cycles(16);
    for (int k = 0; k < 4; k++) begin
      uart_rx = part[k];
      cycles(16);
    end
    uart_rx = part[4];
    cycles(8);
    reset   = 1'b1;
    uart_rx = 1'b1;
    cycles(2);
    @(negedge clk_in);
    chk("mr_valid", 32'(valid_o), 0);
    chk("mr_level", 32'(level_o), 0);
    chk("mr_data", 32'(data_o), 0);
    chk("mr_ferr", 32'(frame_err_o), 0);
    chk("mr_ovr", 32'(overrun_o), 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    cycles(20);
    fe0 = fe_n;
    send(8'hC3, 1'b1, 1'b0);
    @(negedge clk_in);
    chk("mr_c3_lvl", 32'(level_o), 1);
    chk("mr_c3_vld", 32'(valid_o), 1);
    chk("mr_c3_data", 32'(data_o), 32'hC3);
    chk("mr_c3_ferr", 32'(fe_n - fe0), 0);
    chk("no_both", 32'(both_n), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk_in cycles per UART bit (100 MHz, 115200 baud); minimum legal value 4.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving receive FIFO entries; power of two, minimum 2.
REQ-003 The block SHALL have port clk_in, input, width 1, the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port uart_rx, input, width 1, the asynchronous serial line driven from Didactic uart_tx; it idles high.
REQ-006 The block SHALL have port data_o, output, width 8, the FIFO head byte.
REQ-007 The block SHALL have port valid_o, output, width 1, high when the FIFO is non-empty.
REQ-008 The block SHALL have port ready_i, input, width 1, the consumer accept signal.
REQ-009 The block SHALL have port level_o, output, width $clog2(FIFO_DEPTH)+1, the current FIFO occupancy.
REQ-010 The block SHALL have port frame_err_o, output, width 1, a one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun_o, output, width 1, a one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-012 The block SHALL pass uart_rx through a 2-flop synchroniser; all decode SHALL use the synchronised value, which resets to 1.
REQ-013 The receiver FSM SHALL use exactly four states: IDLE, START, DATA, STOP.
REQ-014 From IDLE, a synchronised 1->0 transition SHALL move the FSM to START and clear the bit counter.
REQ-015 In START, the line SHALL be sampled after CLKS_PER_BIT/2 (integer division) cycles: 0 moves to DATA; 1 is a glitch and returns to IDLE with no output.
REQ-016 In DATA, 8 samples SHALL be taken at CLKS_PER_BIT-cycle spacing, shifted in LSB first; after the 8th sample the FSM moves to STOP.
REQ-017 In STOP, one sample SHALL be taken CLKS_PER_BIT cycles after the last data sample.
REQ-018 A stop sample of 1 SHALL push the byte into the FIFO; a stop sample of 0 SHALL discard the byte and pulse frame_err_o for one cycle.
REQ-019 After the stop sample the FSM SHALL return to IDLE; if the line is low it SHALL wait there for a high before accepting a new start edge.
REQ-020 A pushed byte SHALL be visible on data_o, with valid_o high, on the cycle after the stop-sample cycle if the FIFO was empty.
REQ-021 A pop SHALL occur when valid_o and ready_i are both high; data_o SHALL then advance to the next entry on the following cycle.
REQ-022 data_o SHALL be stable while valid_o is high and ready_i is low.
REQ-023 A push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the byte is dropped, overrun_o pulses, and level_o is unchanged.
REQ-024 A simultaneous push and pop when not full SHALL leave level_o unchanged and keep FIFO order.
REQ-025 A pop attempt while empty SHALL be ignored (impossible under REQ-021).
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with full/empty derived from an extra pointer MSB.
REQ-027 frame_err_o and overrun_o SHALL never both be asserted in the same cycle.

Reset
REQ-028 While reset is high: FSM = IDLE; counters and pointers = 0; level_o = 0; valid_o = 0; data_o = 8'h00; frame_err_o = 0; overrun_o = 0; synchroniser flops = 1.
REQ-029 Reset mid-frame SHALL abandon the partial byte and flush the FIFO; after release, the next falling edge starts a fresh frame.

Structure
REQ-030 A package uart_rx_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and the default constants for CLKS_PER_BIT and FIFO_DEPTH.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated once; the FSM, synchroniser and baud counter live in uart_rx_fifo.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Send 8'hA5 with a valid stop bit and ready_i=1 -> valid_o pulses one cycle with data_o=8'hA5, and frame_err_o stays 0.
REQ-033 Drive a 5-cycle low glitch on an idle line -> the FSM returns to IDLE, and valid_o, frame_err_o and level_o stay 0.
REQ-034 Send 8'h3C with stop bit 0 -> frame_err_o pulses once, and level_o stays 0.
REQ-035 With ready_i=0, send 8'h01..8'h05 -> level_o=4, overrun_o pulses on the 5th byte, and pops then return 01,02,03,04 in order.
REQ-036 With the FIFO full, pop in the same cycle as a push of 8'h77 -> level_o stays 4, no overrun_o, and 8'h77 is read last.
REQ-037 Assert reset for 3 cycles during DATA bit 4 of a frame -> all outputs take their REQ-028 values, and the next full frame 8'hC3 is received correctly.
